vsi_leg_seq: RTL and testbench



---
 rtl/vsi_pkg.sv | 18 +
 rtl/vsi_deadtime.sv | 60 ++++++
 rtl/vsi_leg_seq.sv | 113 +++++++++++
 tb/tb_vsi_leg_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vsi_pkg.sv
// Purpose: shared state codes and default timing constants for the inverter-leg sequencer.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package vsi_pkg;

  // Encodings are visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BOOT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam int DT_CYCLES_DEF   = 3;
  localparam int BOOT_CYCLES_DEF = 20;
  localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/vsi_deadtime.sv
// Purpose: dead-time insertion between the PWM level and the complementary gate pair.
// Latency: gates follow a steady s_in one edge later; a level change costs DT_CYCLES gates-off cycles.
// Backpressure: none; s_in is sampled every cycle, pulses shorter than DT_CYCLES are swallowed.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   active    1 while the leg is in RUN; 0 holds gates off, lvl=0, counter=0
//   s_in      requested level (1 = high side, 0 = low side)
//   gh, gl    registered high-side / low-side gate commands
module vsi_deadtime #(
  parameter int DT_CYCLES = 3,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic s_in,
  output logic gh,
  output logic gl
);

  localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DT_CYCLES);

  logic             lvl;
  logic [CNT_W-1:0] cnt;

  // cnt holds the number of consecutive mismatching samples; the gates have
  // been off for exactly cnt cycles when cnt reaches DT_LAST, so the new
  // side may turn on at that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl <= 1'b0;
      cnt <= '0;
      gh  <= 1'b0;
      gl  <= 1'b0;
    end else if (!active) begin
      lvl <= 1'b0;
      cnt <= '0;
      gh  <= 1'b0;
      gl  <= 1'b0;
    end else if (s_in == lvl) begin
      // Steady, or a short pulse ended: restore the applied side.
      cnt <= '0;
      gh  <= lvl;
      gl  <= ~lvl;
    end else if (cnt == DT_LAST) begin
      lvl <= s_in;
      cnt <= '0;
      gh  <= s_in;
      gl  <= ~s_in;
    end else begin
      gh <= 1'b0;
      gl <= 1'b0;
      if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vsi_leg_seq.sv
// Purpose: inverter-leg sequencer: bootstrap precharge, dead-time gated RUN, latched fault shutdown.
// Latency: all outputs registered; state, gate and enable changes appear one edge after the cause.
// Backpressure: none; fault overrides en=0, which overrides normal progression, every cycle.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset (reset forces gates off at once)
//   en         run request (level)
//   s_in       raw PWM level from the comparator
//   fault      external overcurrent/desat fault (level)
//   clr_fault  fault acknowledge (level), honoured only once fault has dropped
//   pwm_en     comparator enable, high only in RUN
//   gh, gl     high-side / low-side gate commands
//   state      current state code (IDLE=0, BOOT=1, RUN=2, FAULT=3)
//   fault_lat  latched fault flag
module vsi_leg_seq
  import vsi_pkg::*;
#(
  parameter int DT_CYCLES   = DT_CYCLES_DEF,
  parameter int BOOT_CYCLES = BOOT_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       s_in,
  input  logic       fault,
  input  logic       clr_fault,
  output logic       pwm_en,
  output logic       gh,
  output logic       gl,
  output logic [1:0] state,
  output logic       fault_lat
);

  // Counter starts at 0 on the first BOOT cycle, so the edge that ends
  // BOOT_CYCLES cycles of gl=1 sees BOOT_CYCLES-1.
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  state_t           state_q;
  state_t           state_nx;
  logic [CNT_W-1:0] boot_cnt;
  logic             boot_gl_q;
  logic             pwm_en_q;
  logic             fault_lat_q;
  logic             dt_active;
  logic             dt_gh;
  logic             dt_gl;

  always_comb begin
    state_nx = state_q;
    if (fault) begin
      state_nx = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE:  if (en) state_nx = ST_BOOT;
        ST_BOOT: begin
          if (!en)                        state_nx = ST_IDLE;
          else if (boot_cnt == BOOT_LAST) state_nx = ST_RUN;
        end
        ST_RUN:   if (!en) state_nx = ST_IDLE;
        ST_FAULT: if (clr_fault) state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // Driven from the next state so the dead-time flops load on the same edge
  // as the state change: the low side stays on seamlessly from BOOT into
  // RUN, and fault / en=0 turn the gates off with one-cycle latency.
  assign dt_active = (state_nx == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      boot_cnt    <= '0;
      boot_gl_q   <= 1'b0;
      pwm_en_q    <= 1'b0;
      fault_lat_q <= 1'b0;
    end else begin
      state_q     <= state_nx;
      boot_gl_q   <= (state_nx == ST_BOOT);
      pwm_en_q    <= (state_nx == ST_RUN);
      fault_lat_q <= (state_nx == ST_FAULT);
      // Held at zero outside BOOT, so every BOOT entry starts a full precharge.
      if (state_nx != ST_BOOT) begin
        boot_cnt <= '0;
      end else if (state_q == ST_BOOT && boot_cnt != {CNT_W{1'b1}}) begin
        boot_cnt <= boot_cnt + 1'b1;
      end
    end
  end

  vsi_deadtime #(
    .DT_CYCLES (DT_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deadtime (
    .clk    (clk),
    .rst    (rst),
    .active (dt_active),
    .s_in   (s_in),
    .gh     (dt_gh),
    .gl     (dt_gl)
  );

  // Both gate sources are flops and mutually exclusive: the dead-time block
  // is cleared whenever the leg is not in RUN, and boot_gl_q is set only in BOOT.
  assign gh        = dt_gh;
  assign gl        = dt_gl | boot_gl_q;
  assign pwm_en    = pwm_en_q;
  assign state     = state_q;
  assign fault_lat = fault_lat_q;

endmodule

// File: tb/tb_vsi_leg_seq.sv
module tb_vsi_leg_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       s_in;
  logic       fault;
  logic       clr_fault;
  logic       pwm_en;
  logic       gh;
  logic       gl;
  logic [1:0] state;
  logic       fault_lat;

  int n_chk  = 0;
  int n_pass = 0;

  vsi_leg_seq dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .s_in      (s_in),
    .fault     (fault),
    .clr_fault (clr_fault),
    .pwm_en    (pwm_en),
    .gh        (gh),
    .gl        (gl),
    .state     (state),
    .fault_lat (fault_lat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st, input logic egh,
                         input logic egl, input logic epwm, input logic eflt);
    chk({tag, ".state"}, {6'd0, state}, {6'd0, st});
    chk({tag, ".gh"}, {7'd0, gh}, {7'd0, egh});
    chk({tag, ".gl"}, {7'd0, gl}, {7'd0, egl});
    chk({tag, ".pwm_en"}, {7'd0, pwm_en}, {7'd0, epwm});
    chk({tag, ".fault_lat"}, {7'd0, fault_lat}, {7'd0, eflt});
  endtask

  // Shoot-through guard across the whole run.
  always @(negedge clk) begin
    if (n_chk > 0) chk("no_shoot_through", {7'd0, gh & gl}, 8'd0);
  end

  initial begin
    rst = 1'b1; en = 1'b0; s_in = 1'b0; fault = 1'b0; clr_fault = 1'b0;
    #7;
    chk_out("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk_out("idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Boot: 20 cycles of low side on, then RUN with low side still on.
    en = 1'b1;
    step();
    chk_out("boot_enter", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      step();
      chk("boot_state", {6'd0, state}, 8'd1);
      chk("boot_gl", {7'd0, gl}, 8'd1);
    end
    step();
    chk_out("run_enter", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);

    // 0 -> 1 with DT=3: three cycles both off, then high side.
    s_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dt01_off_gh", {7'd0, gh}, 8'd0);
      chk("dt01_off_gl", {7'd0, gl}, 8'd0);
    end
    step();
    chk_out("dt01_on", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);

    // 1 -> 0 symmetric.
    s_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dt10_off_gh", {7'd0, gh}, 8'd0);
      chk("dt10_off_gl", {7'd0, gl}, 8'd0);
    end
    step();
    chk_out("dt10_on", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);

    // Two-cycle pulse is swallowed: low side off for 2 cycles, then restored.
    s_in = 1'b1;
    step();
    chk("pulse_c1_gl", {7'd0, gl}, 8'd0);
    step();
    chk("pulse_c2_gl", {7'd0, gl}, 8'd0);
    chk("pulse_c2_gh", {7'd0, gh}, 8'd0);
    s_in = 1'b0;
    step();
    chk_out("pulse_restore", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    step();
    chk_out("pulse_lvl_kept", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);

    // Get the high side on, then fault.
    s_in = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("pre_fault_gh", {7'd0, gh}, 8'd1);
    fault = 1'b1;
    step();
    chk_out("fault_enter", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    clr_fault = 1'b1;
    step();
    chk_out("fault_clr_blocked", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    fault = 1'b0; clr_fault = 1'b0; en = 1'b0; s_in = 1'b0;
    step();
    chk_out("fault_hold", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    clr_fault = 1'b1;
    step();
    chk_out("fault_exit", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_fault = 1'b0;

    // Abort boot at cycle 10, then a full 20-cycle restart.
    en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("boot10_state", {6'd0, state}, 8'd1);
    en = 1'b0;
    step();
    chk_out("boot_abort", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    step();
    chk_out("reboot_enter", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      step();
      chk("reboot_state", {6'd0, state}, 8'd1);
    end
    step();
    chk_out("rerun_enter", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);

    // en=0 together with fault: fault wins.
    en = 1'b0; fault = 1'b1;
    step();
    chk_out("fault_over_en", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    fault = 1'b0; clr_fault = 1'b1;
    step();
    chk("fault_exit2_state", {6'd0, state}, 8'd0);
    clr_fault = 1'b0;

    // Back to RUN, then asynchronous reset in the middle of a dead time.
    en = 1'b1;
    for (int i = 0; i < 21; i++) step();
    chk("run3_state", {6'd0, state}, 8'd2);
    s_in = 1'b1;
    step();
    chk("dt_mid_gl", {7'd0, gl}, 8'd0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("rst_held", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    en = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
